// File: rtl/brcomp_seq.sv
// Multi-cycle RV32I branch comparator: scans operands MSB chunk first, stops at the
// first differing chunk, and returns equal/less/taken over a valid/ready handshake.
module brcomp_seq #(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_rs1_data,
    input  logic [DATA_W-1:0] i_rs2_data,
    input  logic [2:0]        i_funct3,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_br_equal,
    output logic              o_br_less,
    output logic              o_br_taken,
    output logic              o_illegal
);

    localparam int NUM_CHUNKS = DATA_W / CHUNK_W;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [DATA_W-1:0] SIGN_MASK = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0]  a_q, b_q;
    logic [1:0]         f3_q;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CHUNK_W-1:0] a_chunk, b_chunk;
    logic               accept;

    logic valid_d, equal_d, less_d, taken_d, illegal_d;

    // Only funct3[2] (compare kind) and funct3[0] (polarity) matter once accepted.
    function automatic logic resolve_taken(input logic [1:0] f3, input logic eq, input logic lt);
        if (f3[1]) begin
            return lt ^ f3[0];
        end
        return eq ^ f3[0];
    endfunction

    assign o_ready = (state_q == IDLE);
    assign a_chunk = a_q[int'(idx_q) * CHUNK_W +: CHUNK_W];
    assign b_chunk = b_q[int'(idx_q) * CHUNK_W +: CHUNK_W];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        accept    = 1'b0;
        valid_d   = o_valid;
        equal_d   = o_br_equal;
        less_d    = o_br_less;
        taken_d   = o_br_taken;
        illegal_d = o_illegal;

        case (state_q)
            IDLE: begin
                valid_d   = 1'b0;
                equal_d   = 1'b0;
                less_d    = 1'b0;
                taken_d   = 1'b0;
                illegal_d = 1'b0;
                if (i_valid && !i_flush) begin
                    accept = 1'b1;
                    idx_d  = LAST_IDX;
                    if (i_funct3[2:1] == 2'b01) begin
                        state_d   = DONE;
                        valid_d   = 1'b1;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = CMP;
                    end
                end
            end

            CMP: begin
                if (i_flush) begin
                    state_d   = IDLE;
                    valid_d   = 1'b0;
                    equal_d   = 1'b0;
                    less_d    = 1'b0;
                    taken_d   = 1'b0;
                    illegal_d = 1'b0;
                end else if (a_chunk != b_chunk) begin
                    state_d   = DONE;
                    valid_d   = 1'b1;
                    equal_d   = 1'b0;
                    less_d    = (a_chunk < b_chunk);
                    taken_d   = resolve_taken(f3_q, 1'b0, (a_chunk < b_chunk));
                    illegal_d = 1'b0;
                end else if (idx_q == '0) begin
                    state_d   = DONE;
                    valid_d   = 1'b1;
                    equal_d   = 1'b1;
                    less_d    = 1'b0;
                    taken_d   = resolve_taken(f3_q, 1'b1, 1'b0);
                    illegal_d = 1'b0;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end

            DONE: begin
                if (i_flush || i_ready) begin
                    state_d   = IDLE;
                    valid_d   = 1'b0;
                    equal_d   = 1'b0;
                    less_d    = 1'b0;
                    taken_d   = 1'b0;
                    illegal_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            o_valid    <= 1'b0;
            o_br_equal <= 1'b0;
            o_br_less  <= 1'b0;
            o_br_taken <= 1'b0;
            o_illegal  <= 1'b0;
        end else begin
            state_q    <= state_d;
            o_valid    <= valid_d;
            o_br_equal <= equal_d;
            o_br_less  <= less_d;
            o_br_taken <= taken_d;
            o_illegal  <= illegal_d;
        end
    end

    // Flipping the sign bit in signed mode lets the unsigned chunk compare give signed order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_q   <= '0;
            b_q   <= '0;
            f3_q  <= '0;
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
            if (accept) begin
                a_q  <= i_rs1_data ^ (i_funct3[1] ? '0 : SIGN_MASK);
                b_q  <= i_rs2_data ^ (i_funct3[1] ? '0 : SIGN_MASK);
                f3_q <= {i_funct3[2], i_funct3[0]};
            end
        end
    end

endmodule

// File: tb/tb_brcomp_seq.sv
// Directed bench for brcomp_seq: requests push expected results to a scoreboard queue,
// which is popped and checked (including latency) when o_valid rises.
module tb_brcomp_seq;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [2:0]  i_funct3;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic        o_br_equal;
    logic        o_br_less;
    logic        o_br_taken;
    logic        o_illegal;

    typedef struct {
        string tag;
        logic  eq;
        logic  lt;
        logic  tk;
        logic  ill;
        int    lat;
    } exp_t;

    exp_t sb[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    brcomp_seq #(.DATA_W(32), .CHUNK_W(8)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .i_funct3   (i_funct3),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_br_equal (o_br_equal),
        .o_br_less  (o_br_less),
        .o_br_taken (o_br_taken),
        .o_illegal  (o_illegal)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Drives one request through its accept edge; afterwards the bench sits in cycle 1.
    task automatic apply_stimulus(input string tag, input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [2:0] f3, input logic eq, input logic lt,
                                  input logic tk, input logic ill, input int lat,
                                  input bit expect_result);
        int   w;
        exp_t e;
        w = 0;
        while (o_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        if (w >= 20) compare_value({tag, "_ready_wait"}, 32'(o_ready), 32'd1);
        i_valid    = 1'b1;
        i_rs1_data = rs1;
        i_rs2_data = rs2;
        i_funct3   = f3;
        step();
        i_valid    = 1'b0;
        i_rs1_data = 32'hDEAD_BEEF;
        i_rs2_data = 32'h0BAD_F00D;
        i_funct3   = 3'b011;
        if (expect_result) begin
            e.tag = tag; e.eq = eq; e.lt = lt; e.tk = tk; e.ill = ill; e.lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic check_output();
        exp_t e;
        int   cyc;
        e   = sb.pop_front();
        cyc = 1;
        while (o_valid !== 1'b1 && cyc < 30) begin
            step();
            cyc++;
        end
        compare_value({e.tag, "_latency"}, 32'(cyc), 32'(e.lat));
        compare_value({e.tag, "_equal"},   32'(o_br_equal), 32'(e.eq));
        compare_value({e.tag, "_less"},    32'(o_br_less),  32'(e.lt));
        compare_value({e.tag, "_taken"},   32'(o_br_taken), 32'(e.tk));
        compare_value({e.tag, "_illegal"}, 32'(o_illegal),  32'(e.ill));
    endtask

    task automatic consume_check(input string tag);
        step();
        compare_value({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
        compare_value({tag, "_ready_back"}, 32'(o_ready), 32'd1);
    endtask

    task automatic quiet_check(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
            compare_value({tag, "_quiet"}, 32'(o_valid), 32'd0);
        end
    endtask

    initial begin
        i_rst      = 1'b1;
        i_valid    = 1'b0;
        i_rs1_data = '0;
        i_rs2_data = '0;
        i_funct3   = '0;
        i_flush    = 1'b0;
        i_ready    = 1'b1;
        #12;
        compare_value("reset_ready", 32'(o_ready), 32'd1);
        compare_value("reset_valid", 32'(o_valid), 32'd0);
        compare_value("reset_outs",  {28'd0, o_br_equal, o_br_less, o_br_taken, o_illegal}, 32'd0);
        i_rst = 1'b0;
        step();

        // Full-scan equality and early exits on the MSB chunk, signed and unsigned.
        apply_stimulus("beq_full", 32'h12345678, 32'h12345678, 3'b000, 1, 0, 1, 0, 5, 1);
        check_output();
        consume_check("beq_full");
        apply_stimulus("blt_msb", 32'hFFFFFFFF, 32'h00000001, 3'b100, 0, 1, 1, 0, 2, 1);
        check_output();
        consume_check("blt_msb");
        apply_stimulus("bltu_msb", 32'hFFFFFFFF, 32'h00000001, 3'b110, 0, 0, 0, 0, 2, 1);
        check_output();
        consume_check("bltu_msb");
        apply_stimulus("bge_sign", 32'h80000000, 32'h7FFFFFFF, 3'b101, 0, 1, 0, 0, 2, 1);
        check_output();
        consume_check("bge_sign");
        apply_stimulus("bgeu_sign", 32'h80000000, 32'h7FFFFFFF, 3'b111, 0, 0, 1, 0, 2, 1);
        check_output();
        consume_check("bgeu_sign");
        apply_stimulus("bne_lsb", 32'h000000AA, 32'h000000AB, 3'b001, 0, 1, 1, 0, 5, 1);
        check_output();
        consume_check("bne_lsb");

        // Backpressure: result held, new request ignored while DONE.
        i_ready = 1'b0;
        apply_stimulus("bp_beq", 32'h12345678, 32'h12345678, 3'b000, 1, 0, 1, 0, 5, 1);
        check_output();
        i_valid    = 1'b1;
        i_rs1_data = 32'h00000001;
        i_rs2_data = 32'h00000002;
        i_funct3   = 3'b110;
        for (int i = 0; i < 3; i++) begin
            step();
            compare_value("bp_hold_valid", 32'(o_valid), 32'd1);
            compare_value("bp_hold_outs", {28'd0, o_br_equal, o_br_less, o_br_taken, o_illegal}, 32'b1010);
            compare_value("bp_hold_ready", 32'(o_ready), 32'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        consume_check("bp_beq");
        quiet_check("bp_ignored", 6);

        apply_stimulus("illegal_010", 32'h1, 32'h1, 3'b010, 0, 0, 0, 1, 1, 1);
        check_output();
        consume_check("illegal_010");

        // Flush mid-CMP, flush in DONE, and flush racing a request in IDLE.
        apply_stimulus("flush_cmp", 32'h12345678, 32'h12345678, 3'b000, 1, 0, 1, 0, 5, 0);
        step();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        compare_value("flush_cmp_ready", 32'(o_ready), 32'd1);
        compare_value("flush_cmp_valid", 32'(o_valid), 32'd0);
        quiet_check("flush_cmp", 6);
        apply_stimulus("bne_same", 32'd5, 32'd5, 3'b001, 1, 0, 0, 0, 5, 1);
        check_output();
        consume_check("bne_same");

        i_ready = 1'b0;
        apply_stimulus("flush_done", 32'hFFFFFFFF, 32'h00000001, 3'b100, 0, 1, 1, 0, 2, 1);
        check_output();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        i_ready = 1'b1;
        compare_value("flush_done_valid", 32'(o_valid), 32'd0);
        compare_value("flush_done_outs", {28'd0, o_br_equal, o_br_less, o_br_taken, o_illegal}, 32'd0);
        compare_value("flush_done_ready", 32'(o_ready), 32'd1);

        i_valid    = 1'b1;
        i_flush    = 1'b1;
        i_rs1_data = 32'h0;
        i_rs2_data = 32'h0;
        i_funct3   = 3'b000;
        step();
        i_valid = 1'b0;
        i_flush = 1'b0;
        compare_value("flush_idle_ready", 32'(o_ready), 32'd1);
        quiet_check("flush_idle", 6);

        // Async reset between edges, mid-CMP and in DONE.
        apply_stimulus("rst_cmp", 32'h12345678, 32'h12345678, 3'b000, 1, 0, 1, 0, 5, 0);
        step();
        #3;
        i_rst = 1'b1;
        #1;
        compare_value("rst_cmp_ready", 32'(o_ready), 32'd1);
        compare_value("rst_cmp_valid", 32'(o_valid), 32'd0);
        #2;
        i_rst = 1'b0;
        step();

        i_ready = 1'b0;
        apply_stimulus("rst_done", 32'h12345678, 32'h12345678, 3'b000, 1, 0, 1, 0, 5, 1);
        check_output();
        #3;
        i_rst = 1'b1;
        #1;
        compare_value("rst_done_ready", 32'(o_ready), 32'd1);
        compare_value("rst_done_valid", 32'(o_valid), 32'd0);
        compare_value("rst_done_outs", {28'd0, o_br_equal, o_br_less, o_br_taken, o_illegal}, 32'd0);
        #2;
        i_rst   = 1'b0;
        i_ready = 1'b1;
        step();

        apply_stimulus("blt_again", 32'hFFFFFFFF, 32'h00000001, 3'b100, 0, 1, 1, 0, 2, 1);
        check_output();
        consume_check("blt_again");
        apply_stimulus("bltu_again", 32'hFFFFFFFF, 32'h00000001, 3'b110, 0, 0, 0, 0, 2, 1);
        check_output();
        consume_check("bltu_again");

        compare_value("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/brcomp_seq.md
Name: brcomp_seq

Overview:
Parametrised, multi-cycle branch comparator and branch resolver for the RV32I datapath family. It compares rs1 and rs2 one chunk at a time, starting at the MSB chunk, and stops early at the first chunk that differs. It decodes branch funct3 into equal, less and taken results, and delivers them over a valid/ready handshake. It replaces the single-cycle comparator wherever a narrow comparator slice must be time-shared across cycles.

Parameters:
DATA_W, 32, operand width in bits.
CHUNK_W, 8, bits compared per cycle; must divide DATA_W exactly. NUM_CHUNKS = DATA_W/CHUNK_W is a localparam.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_valid  input  1  request valid.
o_ready  output  1  block can accept a request; high only in IDLE.
i_rs1_data  input  DATA_W  operand A.
i_rs2_data  input  DATA_W  operand B.
i_funct3  input  3  branch funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
i_flush  input  1  synchronous abort of any in-flight request.
o_valid  output  1  result valid.
i_ready  input  1  consumer accepts result.
o_br_equal  output  1  rs1 == rs2.
o_br_less  output  1  rs1 < rs2; signed unless funct3[1]=1.
o_br_taken  output  1  branch taken.
o_illegal  output  1  funct3 is 010 or 011.

Behaviour:
- Reset (async, i_rst=1): state=IDLE; o_valid, o_br_equal, o_br_less, o_br_taken, o_illegal=0; o_ready=1. Reset wins over everything, including mid-CMP and DONE. An in-flight request is discarded.
- States: IDLE, CMP, DONE. All outputs except o_ready are registered.
- IDLE:
  - Accept when i_valid & o_ready & ~i_flush at a clock edge.
  - Latch operands and funct3; chunk index = NUM_CHUNKS-1.
  - Signed mode (funct3[1]=0): invert bit DATA_W-1 of both latched operands, so an unsigned chunk compare yields the signed order. Equality is unaffected by the inversion.
  - funct3 010/011: go directly to DONE with equal=0, less=0, taken=0, illegal=1.
  - Otherwise go to CMP.
- CMP, one chunk per cycle:
  - If A chunk != B chunk: less = (A chunk < B chunk) unsigned, equal=0, go to DONE.
  - Else if index==0: equal=1, less=0, go to DONE.
  - Else decrement index.
- Latency: the accept edge is cycle 0. If the deciding chunk is the k-th chunk examined (1..NUM_CHUNKS), o_valid is first high in cycle k+1. For an illegal funct3, o_valid is high in cycle 1.
- taken:
  - BEQ = equal.
  - BNE = ~equal.
  - BLT / BLTU = less.
  - BGE / BGEU = ~less.
- DONE:
  - o_valid=1; results are held stable while i_ready=0.
  - On i_ready=1, return to IDLE; o_valid=0 in the next cycle; o_ready=1 in the next cycle.
  - No request is accepted in the same cycle a result is consumed.
- i_flush (synchronous):
  - From CMP or DONE, go to IDLE at the next edge; o_valid and all result outputs clear to 0; no result is delivered.
  - In IDLE with i_valid=1, flush wins and the request is not accepted.
- i_rs*/i_funct3 changes after acceptance have no effect.
- CHUNK_W == DATA_W: CMP always takes exactly 1 cycle.

Test Plan:
Configuration for all scenarios: DATA_W=32, CHUNK_W=8.

1. BEQ, rs1=rs2=0x12345678 -> full scan; o_valid in cycle 5; equal=1, less=0, taken=1, illegal=0.
2. BLT, rs1=0xFFFFFFFF, rs2=0x00000001 -> MSB chunk decides; o_valid in cycle 2; less=1, taken=1. Repeat as BLTU -> less=0, taken=0, o_valid in cycle 2.
3. BGE, rs1=0x80000000, rs2=0x7FFFFFFF -> less=1, taken=0. BGEU -> less=0, taken=1. BNE, rs1=0x000000AA, rs2=0x000000AB -> o_valid in cycle 5; equal=0, less=1, taken=1.
4. Backpressure: scenario 1 with i_ready=0 for 3 cycles in DONE -> outputs held constant, o_ready=0, a concurrent i_valid is ignored. After i_ready=1, o_ready=1 in the following cycle. Also funct3=010 -> o_valid in cycle 1; illegal=1, taken=0.
5. i_flush in cycle 2 of scenario 1 -> IDLE in cycle 3; o_valid never asserts. A fresh BNE, rs1=5, rs2=5, is then accepted -> taken=0.
6. Async reset asserted mid-CMP, between clock edges -> outputs 0 and o_ready=1 immediately. After release, scenario 2 reproduces exactly.
